// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
// Shared constants and types for the multiplexed 7-segment scan peripheral:
//   - bus register addresses (DATA, CTRL, STATUS)
//   - active-low segment patterns {g,f,e,d,c,b,a} for digits 0-9, the dash
//     shown for non-BCD nibbles, and the all-off pattern
//   - ctrl_t: the architecturally visible CTRL register fields
// -----------------------------------------------------------------------------
package seg7_pkg;

    localparam logic [4:0] ADDR_DATA   = 5'h04;
    localparam logic [4:0] ADDR_CTRL   = 5'h08;
    localparam logic [4:0] ADDR_STATUS = 5'h0C;

    localparam logic [6:0] SEG_0    = 7'h40;
    localparam logic [6:0] SEG_1    = 7'h79;
    localparam logic [6:0] SEG_2    = 7'h24;
    localparam logic [6:0] SEG_3    = 7'h30;
    localparam logic [6:0] SEG_4    = 7'h19;
    localparam logic [6:0] SEG_5    = 7'h12;
    localparam logic [6:0] SEG_6    = 7'h02;
    localparam logic [6:0] SEG_7    = 7'h78;
    localparam logic [6:0] SEG_8    = 7'h00;
    localparam logic [6:0] SEG_9    = 7'h10;
    localparam logic [6:0] SEG_DASH = 7'h3F;
    localparam logic [6:0] SEG_OFF  = 7'h7F;

    // Only EN (bit0) and the DP mask (bits[7:4]) are stored; bits[3:1] read 0.
    typedef struct packed {
        logic [3:0] dp_mask;
        logic       en;
    } ctrl_t;

endpackage

// File: rtl/seg7_decode.sv
// -----------------------------------------------------------------------------
// seg7_decode
// Combinational BCD nibble to active-low 7-segment pattern.
// Ports:
//   nibble_i  [3:0]  digit value
//   seg_o     [6:0]  segments {g,f,e,d,c,b,a}, active-low
//   invalid_o        high when the nibble is not a BCD digit (A-F); the
//                    segment output then shows a dash
// -----------------------------------------------------------------------------
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o,
    output logic       invalid_o
);

    // Digit lookup; anything outside 0-9 becomes a dash and is flagged.
    always_comb begin
        seg_o     = SEG_DASH;
        invalid_o = 1'b0;
        case (nibble_i)
            4'h0:    seg_o = SEG_0;
            4'h1:    seg_o = SEG_1;
            4'h2:    seg_o = SEG_2;
            4'h3:    seg_o = SEG_3;
            4'h4:    seg_o = SEG_4;
            4'h5:    seg_o = SEG_5;
            4'h6:    seg_o = SEG_6;
            4'h7:    seg_o = SEG_7;
            4'h8:    seg_o = SEG_8;
            4'h9:    seg_o = SEG_9;
            default: begin
                seg_o     = SEG_DASH;
                invalid_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/peripheral_seg7_scan.sv
// -----------------------------------------------------------------------------
// peripheral_seg7_scan
// Memory-mapped 4-digit multiplexed 7-segment driver for a packed BCD word.
// The CPU writes the word to a shadow register; it moves to the displayed
// (active) register at a frame boundary, or immediately while scanning is off.
//
// Parameter:
//   CLK_DIV  clk cycles per digit-scan tick (>= 2)
// Ports:
//   clk, reset (async, active-low)
//   d_in[15:0], cs, addr[4:0], rd, wr   bus side
//   d_out[15:0]   registered read data (0 when not reading)
//   an[3:0]       digit enables, active-low, an[0] = least significant digit
//   seg[6:0]      segments {g,f,e,d,c,b,a}, active-low
//   dp            decimal point, active-low
// Build option:
//   SEG7_LZB_EN   when defined, leading zero digits (3..1) are blanked
// -----------------------------------------------------------------------------
module peripheral_seg7_scan
    import seg7_pkg::*;
#(
    parameter int CLK_DIV = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] d_in,
    input  logic        cs,
    input  logic [4:0]  addr,
    input  logic        rd,
    input  logic        wr,
    output logic [15:0] d_out,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int            PW        = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);

    logic [15:0]   shadow_q, shadow_d;
    logic [15:0]   active_q, active_d;
    ctrl_t         ctrl_q, ctrl_d;
    logic          pending_q, pending_d;
    logic          invalid_q, invalid_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [1:0]    idx_q, idx_d;
    logic [15:0]   d_out_q, d_out_d;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;

    logic          wr_data_s, wr_ctrl_s, wr_stat_s;
    logic          tick_s, frame_s, xfer_s, blank_s;
    logic [3:0]    nib_s;
    logic [6:0]    dec_seg_s;
    logic          dec_inv_s;
    logic [15:0]   rdata_s;

    assign wr_data_s = cs && wr && (addr == ADDR_DATA);
    assign wr_ctrl_s = cs && wr && (addr == ADDR_CTRL);
    assign wr_stat_s = cs && wr && (addr == ADDR_STATUS);

    assign tick_s  = ctrl_q.en && (presc_q == PRESC_MAX);
    assign frame_s = tick_s && (idx_q == 2'd3);
    // With scanning off there is no frame to wait for: transfer right away.
    assign xfer_s  = pending_q && (ctrl_q.en ? frame_s : 1'b1);
    assign nib_s   = active_q[{idx_q, 2'b00} +: 4];

    seg7_decode u_decode (
        .nibble_i  (nib_s),
        .seg_o     (dec_seg_s),
        .invalid_o (dec_inv_s)
    );

    // Leading-zero blanking: the current digit is dark when it and all higher nibbles are zero.
    always_comb begin
        blank_s = 1'b0;
`ifdef SEG7_LZB_EN
        case (idx_q)
            2'd3:    blank_s = (active_q[15:12] == 4'h0);
            2'd2:    blank_s = (active_q[15:8]  == 8'h00);
            2'd1:    blank_s = (active_q[15:4]  == 12'h000);
            default: blank_s = 1'b0;
        endcase
`else
        blank_s = 1'b0;
`endif
    end

    // Read-data multiplexer.
    always_comb begin
        rdata_s = 16'h0000;
        case (addr)
            ADDR_DATA:   rdata_s = shadow_q;
            ADDR_CTRL:   rdata_s = {8'h00, ctrl_q.dp_mask, 3'b000, ctrl_q.en};
            ADDR_STATUS: rdata_s = {12'h000, idx_q, invalid_q, pending_q};
            default:     rdata_s = 16'h0000;
        endcase
    end

    // Next-state logic for bus registers, scan counters and display outputs.
    always_comb begin
        shadow_d  = shadow_q;
        active_d  = active_q;
        ctrl_d    = ctrl_q;
        pending_d = pending_q;
        invalid_d = invalid_q;
        presc_d   = presc_q;
        idx_d     = idx_q;
        d_out_d   = 16'h0000;
        an_d      = 4'hF;
        seg_d     = SEG_OFF;
        dp_d      = 1'b1;

        // Transfer first, then a same-cycle DATA write re-arms pending.
        if (xfer_s) begin
            active_d  = shadow_q;
            pending_d = 1'b0;
        end else begin
            active_d  = active_q;
        end
        if (wr_data_s) begin
            shadow_d  = d_in;
            pending_d = 1'b1;
        end else begin
            shadow_d  = shadow_q;
        end

        if (wr_ctrl_s) begin
            ctrl_d.en      = d_in[0];
            ctrl_d.dp_mask = d_in[7:4];
        end else begin
            ctrl_d = ctrl_q;
        end

        // A new invalid digit overrides a same-cycle software clear.
        if (ctrl_q.en && dec_inv_s) begin
            invalid_d = 1'b1;
        end else if (wr_stat_s && d_in[1]) begin
            invalid_d = 1'b0;
        end else begin
            invalid_d = invalid_q;
        end

        if (!ctrl_q.en) begin
            presc_d = {PW{1'b0}};
            idx_d   = 2'd0;
        end else if (tick_s) begin
            presc_d = {PW{1'b0}};
            idx_d   = idx_q + 2'd1;
        end else begin
            presc_d = presc_q + PW'(1);
            idx_d   = idx_q;
        end

        if (cs && rd) begin
            d_out_d = rdata_s;
        end else begin
            d_out_d = 16'h0000;
        end

        if (ctrl_q.en) begin
            an_d  = blank_s ? 4'hF : ~(4'b0001 << idx_q);
            seg_d = blank_s ? SEG_OFF : dec_seg_s;
            dp_d  = ~ctrl_q.dp_mask[idx_q];
        end else begin
            an_d  = 4'hF;
            seg_d = SEG_OFF;
            dp_d  = 1'b1;
        end
    end

    // State and output registers; reset acts asynchronously, mid-scan included.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shadow_q  <= 16'h0000;
            active_q  <= 16'h0000;
            ctrl_q    <= '0;
            pending_q <= 1'b0;
            invalid_q <= 1'b0;
            presc_q   <= {PW{1'b0}};
            idx_q     <= 2'd0;
            d_out_q   <= 16'h0000;
            an_q      <= 4'hF;
            seg_q     <= SEG_OFF;
            dp_q      <= 1'b1;
        end else begin
            shadow_q  <= shadow_d;
            active_q  <= active_d;
            ctrl_q    <= ctrl_d;
            pending_q <= pending_d;
            invalid_q <= invalid_d;
            presc_q   <= presc_d;
            idx_q     <= idx_d;
            d_out_q   <= d_out_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
            dp_q      <= dp_d;
        end
    end

    assign d_out = d_out_q;
    assign an    = an_q;
    assign seg   = seg_q;
    assign dp    = dp_q;

endmodule

// File: tb/tb_peripheral_seg7_scan.sv
// -----------------------------------------------------------------------------
// tb_peripheral_seg7_scan
// Directed table of bus operations with hand-computed expectations, followed
// by random bus traffic. Every clock is also compared against a cycle-count
// based reference model of the display and register behaviour.
// -----------------------------------------------------------------------------
module tb_peripheral_seg7_scan;

    localparam int CLK_DIV = 4;
    localparam int FRAME   = 4 * CLK_DIV;

    localparam int OP_WR   = 0;
    localparam int OP_RD   = 1;
    localparam int OP_IDLE = 2;
    localparam int OP_RST  = 3;

    localparam logic [4:0] A_DATA = 5'h04;
    localparam logic [4:0] A_CTRL = 5'h08;
    localparam logic [4:0] A_STAT = 5'h0C;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] d_in  = 16'h0000;
    logic        cs    = 1'b0;
    logic [4:0]  addr  = 5'h00;
    logic        rd    = 1'b0;
    logic        wr    = 1'b0;
    logic [15:0] d_out;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    peripheral_seg7_scan #(.CLK_DIV(CLK_DIV)) dut (
        .clk   (clk),
        .reset (reset),
        .d_in  (d_in),
        .cs    (cs),
        .addr  (addr),
        .rd    (rd),
        .wr    (wr),
        .d_out (d_out),
        .an    (an),
        .seg   (seg),
        .dp    (dp)
    );

    // ---------------- reference model ----------------
    logic [6:0]  lut [0:9];
    logic [15:0] m_shadow, m_active, m_dout;
    logic        m_en, m_pend, m_inv, m_dp;
    logic [3:0]  m_dpm, m_an;
    logic [6:0]  m_seg;
    int          m_cyc;   // cycles since scanning started, modulo one frame

    task automatic model_reset();
        m_shadow = 16'h0; m_active = 16'h0; m_dout = 16'h0;
        m_en = 1'b0; m_pend = 1'b0; m_inv = 1'b0; m_dp = 1'b1;
        m_dpm = 4'h0; m_an = 4'hF; m_seg = 7'h7F; m_cyc = 0;
    endtask

    task automatic model_step();
        int          idx;
        int          nxt_cyc;
        logic [3:0]  nib;
        logic        blank;
        logic        xfer;
        logic [15:0] rv;
        idx = (m_cyc / CLK_DIV) % 4;
        nib = m_active[4*idx +: 4];
`ifdef SEG7_LZB_EN
        blank = (idx > 0) && ((m_active >> (4*idx)) == 16'h0);
`else
        blank = 1'b0;
`endif
        xfer = m_pend && (!m_en || (m_cyc == FRAME - 1));
        case (addr)
            A_DATA:  rv = m_shadow;
            A_CTRL:  rv = {8'h00, m_dpm, 3'b000, m_en};
            A_STAT:  rv = {12'h000, 2'(idx), m_inv, m_pend};
            default: rv = 16'h0000;
        endcase
        m_dout = (cs && rd) ? rv : 16'h0000;
        if (m_en) begin
            m_an  = blank ? 4'hF : ~(4'b0001 << idx);
            m_seg = blank ? 7'h7F : ((nib <= 4'd9) ? lut[nib] : 7'h3F);
            m_dp  = ~m_dpm[idx];
        end else begin
            m_an = 4'hF; m_seg = 7'h7F; m_dp = 1'b1;
        end
        if (cs && wr && addr == A_STAT && d_in[1]) m_inv = 1'b0;
        if (m_en && nib > 4'd9) m_inv = 1'b1;
        if (xfer) begin
            m_active = m_shadow;
            m_pend   = 1'b0;
        end
        if (cs && wr && addr == A_DATA) begin
            m_shadow = d_in;
            m_pend   = 1'b1;
        end
        nxt_cyc = m_en ? (m_cyc + 1) % FRAME : 0;
        m_cyc   = nxt_cyc;
        if (cs && wr && addr == A_CTRL) begin
            m_en  = d_in[0];
            m_dpm = d_in[7:4];
        end
    endtask

    // ---------------- helpers ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic clk_step();
        model_step();
        @(posedge clk);
        #1;
        chk("model", {4'h0, d_out, an, seg, dp}, {4'h0, m_dout, m_an, m_seg, m_dp});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) clk_step();
    endtask

    task automatic bus_wr(input logic [4:0] a, input logic [15:0] d);
        cs = 1'b1; wr = 1'b1; addr = a; d_in = d;
        clk_step();
        cs = 1'b0; wr = 1'b0;
    endtask

    task automatic bus_rd(input logic [4:0] a);
        cs = 1'b1; rd = 1'b1; addr = a;
        clk_step();
        cs = 1'b0; rd = 1'b0;
    endtask

    typedef struct {
        int          op;
        logic [4:0]  a;
        logic [15:0] d;      // write data, or expected read data
        int          n;      // idle cycles before checking an/seg
        logic [3:0]  e_an;
        logic [6:0]  e_seg;
        string       nm;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input int op, input logic [4:0] a, input logic [15:0] d,
                       input int n, input logic [3:0] e_an, input logic [6:0] e_seg,
                       input string nm);
        vec_t v;
        v.op = op; v.a = a; v.d = d; v.n = n; v.e_an = e_an; v.e_seg = e_seg; v.nm = nm;
        tbl.push_back(v);
    endtask

    function automatic logic [15:0] rand_data();
        logic [15:0] r;
        r = 16'($urandom);
        if ($urandom_range(0, 9) < 7) begin
            for (int k = 0; k < 4; k++) r[4*k +: 4] = 4'($urandom_range(0, 9));
        end
        return r;
    endfunction

    initial begin
        int          r;
        logic [15:0] d;
        lut[0] = 7'h40; lut[1] = 7'h79; lut[2] = 7'h24; lut[3] = 7'h30; lut[4] = 7'h19;
        lut[5] = 7'h12; lut[6] = 7'h02; lut[7] = 7'h78; lut[8] = 7'h00; lut[9] = 7'h10;
        model_reset();

        // Scan walk of 1234; update to 5678 mid-frame; invalid digit; reset at index 2.
        add(OP_RD,   A_STAT, 16'h0000, 0, 4'h0, 7'h00, "status_after_reset");
        add(OP_WR,   A_DATA, 16'h1234, 0, 4'h0, 7'h00, "");
        add(OP_WR,   A_CTRL, 16'h0001, 0, 4'h0, 7'h00, "");
        add(OP_IDLE, 5'h00,  16'h0000, 1, 4'hE, 7'h19, "d0_1234");
        add(OP_IDLE, 5'h00,  16'h0000, 4, 4'hD, 7'h30, "d1_1234");
        add(OP_IDLE, 5'h00,  16'h0000, 4, 4'hB, 7'h24, "d2_1234");
        add(OP_IDLE, 5'h00,  16'h0000, 4, 4'h7, 7'h79, "d3_1234");
        add(OP_IDLE, 5'h00,  16'h0000, 4, 4'hE, 7'h19, "d0_wrap");
        add(OP_IDLE, 5'h00,  16'h0000, 3, 4'hE, 7'h19, "d0_hold");
        add(OP_WR,   A_DATA, 16'h5678, 0, 4'h0, 7'h00, "");
        add(OP_RD,   A_STAT, 16'h0005, 0, 4'h0, 7'h00, "status_pending");
        add(OP_IDLE, 5'h00,  16'h0000, 10, 4'h7, 7'h79, "d3_still_old");
        add(OP_IDLE, 5'h00,  16'h0000, 1, 4'hE, 7'h00, "d0_new_5678");
        add(OP_RD,   A_STAT, 16'h0000, 0, 4'h0, 7'h00, "status_transferred");
        add(OP_WR,   A_DATA, 16'h00A0, 0, 4'h0, 7'h00, "");
        add(OP_IDLE, 5'h00,  16'h0000, 18, 4'hD, 7'h3F, "d1_dash");
        add(OP_RD,   A_STAT, 16'h0006, 0, 4'h0, 7'h00, "status_invalid");
        add(OP_IDLE, 5'h00,  16'h0000, 2, 4'hD, 7'h3F, "d1_dash_hold");
        add(OP_WR,   A_STAT, 16'h0002, 0, 4'h0, 7'h00, "");
        add(OP_RD,   A_STAT, 16'h0008, 0, 4'h0, 7'h00, "status_cleared");
        add(OP_IDLE, 5'h00,  16'h0000, 10, 4'hE, 7'h40, "d0_zero");
        add(OP_WR,   A_STAT, 16'h0002, 0, 4'h0, 7'h00, "");
        add(OP_RD,   A_STAT, 16'h0006, 0, 4'h0, 7'h00, "status_set_wins");
        add(OP_IDLE, 5'h00,  16'h0000, 2, 4'hD, 7'h3F, "d1_before_reset");
        add(OP_RST,  5'h00,  16'h0000, 0, 4'h0, 7'h00, "async_reset");
        add(OP_IDLE, 5'h00,  16'h0000, 5, 4'hF, 7'h7F, "blank_after_reset");
        add(OP_RD,   A_CTRL, 16'h0000, 0, 4'h0, 7'h00, "ctrl_after_reset");
        add(OP_RD,   A_STAT, 16'h0000, 0, 4'h0, 7'h00, "status_after_rst2");
        // Leading-zero case 0x0007.
        add(OP_WR,   A_DATA, 16'h0007, 0, 4'h0, 7'h00, "");
        add(OP_WR,   A_CTRL, 16'h0001, 0, 4'h0, 7'h00, "");
        add(OP_IDLE, 5'h00,  16'h0000, 1, 4'hE, 7'h78, "lz_d0");
`ifdef SEG7_LZB_EN
        add(OP_IDLE, 5'h00,  16'h0000, 4, 4'hF, 7'h7F, "lz_d1");
        add(OP_IDLE, 5'h00,  16'h0000, 4, 4'hF, 7'h7F, "lz_d2");
`else
        add(OP_IDLE, 5'h00,  16'h0000, 4, 4'hD, 7'h40, "lz_d1");
        add(OP_IDLE, 5'h00,  16'h0000, 4, 4'hB, 7'h40, "lz_d2");
`endif
        add(OP_RD,   A_DATA, 16'h0007, 0, 4'h0, 7'h00, "data_readback");
        add(OP_RD,   5'h10,  16'h0000, 0, 4'h0, 7'h00, "unmapped_read");

        // Reset state, then release away from the clock edge.
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {4'h0, d_out, an, seg, dp}, {4'h0, 16'h0000, 4'hF, 7'h7F, 1'b1});
        reset = 1'b1;

        for (int k = 0; k < tbl.size(); k++) begin
            case (tbl[k].op)
                OP_WR: bus_wr(tbl[k].a, tbl[k].d);
                OP_RD: begin
                    bus_rd(tbl[k].a);
                    chk(tbl[k].nm, {16'h0, d_out}, {16'h0, tbl[k].d});
                end
                OP_IDLE: begin
                    idle(tbl[k].n);
                    chk({tbl[k].nm, "_an"},  {28'h0, an},  {28'h0, tbl[k].e_an});
                    chk({tbl[k].nm, "_seg"}, {25'h0, seg}, {25'h0, tbl[k].e_seg});
                end
                OP_RST: begin
                    #2;
                    reset = 1'b0;
                    #1;
                    chk(tbl[k].nm, {4'h0, d_out, an, seg, dp}, {4'h0, 16'h0000, 4'hF, 7'h7F, 1'b1});
                    model_reset();
                    repeat (2) @(posedge clk);
                    #1;
                    reset = 1'b1;
                end
                default: ;
            endcase
        end

        // Random traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            r = $urandom_range(0, 99);
            if (r < 55) begin
                clk_step();
            end else if (r < 66) begin
                bus_wr(A_DATA, rand_data());
            end else if (r < 72) begin
                d = 16'($urandom);
                d[0] = ($urandom_range(0, 9) != 0);
                bus_wr(A_CTRL, d);
            end else if (r < 77) begin
                bus_wr(A_STAT, 16'($urandom));
            end else if (r < 80) begin
                // Write strobe without chip select must be ignored.
                cs = 1'b0; wr = 1'b1; addr = A_DATA; d_in = 16'($urandom);
                clk_step();
                wr = 1'b0;
            end else if (r < 83) begin
                bus_wr(5'($urandom), 16'($urandom));
            end else begin
                case ($urandom_range(0, 3))
                    0:       bus_rd(A_DATA);
                    1:       bus_rd(A_CTRL);
                    2:       bus_rd(A_STAT);
                    default: bus_rd(5'($urandom));
                endcase
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
